// File: rtl/uart_tx_scheduler_if.sv
// Signal bundle between two byte requesters, the scheduler and a UART transmitter.
// The master modport is the scheduler's view; slave is the surrounding environment.
interface uart_tx_scheduler_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic [1:0] grant;
  logic       busy;
  logic       timeout_err;

  modport master (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  tx_done,
    output req0_ready, req1_ready,
    output tx_start, tx_data, grant, busy, timeout_err
  );

  modport slave (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output tx_done,
    input  req0_ready, req1_ready,
    input  tx_start, tx_data, grant, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Two-requester byte scheduler feeding a single UART transmitter, with packet
// lock, round-robin fairness, an inter-frame gap and a tx_done timeout.
module uart_tx_scheduler #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  localparam logic [15:0] TO_LIMIT   = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] GAP_LOAD   = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
  localparam state_t      POST_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_t      state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [1:0]  grant_q, grant_d;
  logic        lock_q, lock_d;
  logic        prio_q, prio_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic        run_q;

  logic        sel1;
  logic        ready0, ready1;
  logic        hs;
  logic [7:0]  hs_data;
  logic        hs_last;
  logic        timeout_pulse;

  // prio_q names the requester that wins a tie (or is offered ready when nobody is valid).
  always_comb begin
    sel1 = prio_q;
    if (lock_q)                               sel1 = grant_q[1];
    else if (bus.req0_valid ^ bus.req1_valid) sel1 = bus.req1_valid;
  end

  // run_q keeps ready low until the first clock edge after reset release.
  assign ready0  = run_q && (state_q == IDLE) && !sel1;
  assign ready1  = run_q && (state_q == IDLE) &&  sel1;
  assign hs      = (ready0 && bus.req0_valid) || (ready1 && bus.req1_valid);
  assign hs_data = sel1 ? bus.req1_data : bus.req0_data;
  assign hs_last = sel1 ? bus.req1_last : bus.req0_last;

  always_comb begin
    state_d       = state_q;
    tx_data_d     = tx_data_q;
    grant_d       = grant_q;
    lock_d        = lock_q;
    prio_d        = prio_q;
    to_cnt_d      = to_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    timeout_pulse = 1'b0;

    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d   = START;
          tx_data_d = hs_data;
          grant_d   = sel1 ? 2'b10 : 2'b01;
          lock_d    = !hs_last;
          prio_d    = !sel1;
          to_cnt_d  = 16'd0;
        end
      end
      START: begin
        state_d  = WAIT_DONE;
        to_cnt_d = to_cnt_q + 16'd1;
      end
      WAIT_DONE: begin
        // A tx_done arriving in the limit cycle still counts as success.
        if (bus.tx_done) begin
          state_d   = POST_FRAME;
          gap_cnt_d = GAP_LOAD;
        end else if (to_cnt_q == TO_LIMIT) begin
          timeout_pulse = 1'b1;
          lock_d        = 1'b0;
          state_d       = POST_FRAME;
          gap_cnt_d     = GAP_LOAD;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (gap_cnt_q == 16'd0) state_d   = IDLE;
        else                    gap_cnt_d = gap_cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase

    // Ownership is released on return to IDLE unless a packet is still locked.
    if ((state_d == IDLE) && !lock_d) grant_d = 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_data_q <= 8'h00;
      grant_q   <= 2'b00;
      lock_q    <= 1'b0;
      prio_q    <= 1'b0;
      to_cnt_q  <= 16'd0;
      gap_cnt_q <= 16'd0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      lock_q    <= lock_d;
      prio_q    <= prio_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      run_q     <= 1'b1;
    end
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.tx_start    = (state_q == START);
  assign bus.tx_data     = tx_data_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.timeout_err = timeout_pulse;

endmodule
